// File: rtl/f3_inst_extract.sv
// Fetch stage 3: queues cache lines from the instruction buffer and hands decode
// one 32-bit instruction per cycle, starting at each line's entry slot.
module f3_inst_extract #(
  parameter int XLEN    = 32,
  parameter int CL_SIZE = 128,
  parameter int QDEPTH  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               line_valid,
  output logic               line_ready,
  input  logic [CL_SIZE-1:0] line_data,
  input  logic [XLEN-1:0]    line_pc,
  input  logic               line_exc,
  input  logic               flush,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [31:0]        inst,
  output logic [XLEN-1:0]    inst_pc,
  output logic               inst_exc,
  output logic               inst_last
);

  localparam int SLOTS = CL_SIZE / 32;
  localparam int SW    = $clog2(SLOTS);
  localparam int OFF   = $clog2(CL_SIZE / 8);
  localparam int PW    = $clog2(QDEPTH);
  localparam int CW    = PW + 1;
  localparam logic [31:0] EXC_NOP = 32'h0000_0013;

  logic [CL_SIZE-1:0] q_data [QDEPTH];
  logic [XLEN-1:0]    q_pc   [QDEPTH];
  logic               q_exc  [QDEPTH];

  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [SW-1:0] slot;

  logic [CL_SIZE-1:0] head_data;
  logic [XLEN-1:0]    head_pc;
  logic               head_exc;
  logic [31:0]        slot_word;
  logic               push, fire, pop, head_last;

  assign head_data = q_data[rd_ptr];
  assign head_pc   = q_pc[rd_ptr];
  assign head_exc  = q_exc[rd_ptr];

  // Refusal uses the pre-pop count, so a full queue never accepts while draining.
  assign line_ready = !rst && !flush && (count < CW'(QDEPTH));
  assign push       = line_valid && line_ready;
  assign fire       = inst_valid && inst_ready;
  assign head_last  = head_exc || (slot == SW'(SLOTS - 1));
  assign pop        = fire && head_last;

  always_comb begin
    slot_word = '0;
    for (int k = 0; k < SLOTS; k++) begin
      if (slot == SW'(k)) slot_word = head_data[32*k +: 32];
    end
  end

  // Outputs are driven purely from queue state; an empty queue presents zeros.
  always_comb begin
    inst_valid = 1'b0;
    inst       = '0;
    inst_pc    = '0;
    inst_exc   = 1'b0;
    inst_last  = 1'b0;
    if (count != '0) begin
      inst_valid = 1'b1;
      inst       = head_exc ? EXC_NOP : slot_word;
      inst_pc    = {head_pc[XLEN-1:OFF], slot, 2'b00};
      inst_exc   = head_exc;
      inst_last  = head_last;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_data[wr_ptr] <= line_data;
      q_pc[wr_ptr]   <= line_pc;
      q_exc[wr_ptr]  <= line_exc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      slot   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // The slot must already point at the new head's entry slot when it surfaces.
      if (pop) begin
        if (count > CW'(1))
          slot <= q_pc[rd_ptr + PW'(1)][OFF-1:2];
        else if (push)
          slot <= line_pc[OFF-1:2];
      end else if (fire) begin
        slot <= slot + SW'(1);
      end else if (push && count == '0) begin
        slot <= line_pc[OFF-1:2];
      end
    end
  end

endmodule
